// File: rtl/burst_slave_pkg.sv
// Shared constants, FSM encoding and range helper for the burst RAM slave.
package burst_slave_pkg;

  localparam int unsigned BURST_W = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned CNT_W   = BURST_W + 1;
  localparam int unsigned EXT_W   = DATA_W + 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_READ_WAIT  = 3'd1;
  localparam logic [2:0] ST_READ_BURST = 3'd2;
  localparam logic [2:0] ST_READ_END   = 3'd3;
  localparam logic [2:0] ST_WRITE      = 3'd4;
  localparam logic [2:0] ST_ERROR      = 3'd5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wr_beat_t;

  // True when words word_idx .. word_idx+burst all fit in a RAM of 2^depth_log2 words.
  function automatic logic inRange(input logic [DATA_W-1:0]  word_idx,
                                   input logic [BURST_W-1:0] burst,
                                   input int unsigned        depth_log2);
    logic [EXT_W-1:0] end_excl;
    end_excl = EXT_W'(word_idx) + EXT_W'(burst) + EXT_W'(1);
    return end_excl <= (EXT_W'(1) << depth_log2);
  endfunction

endpackage

// File: rtl/burst_slave_ram.sv
// Single-port word RAM with byte-lane writes and a registered read port that returns 0 when idle.
module burst_slave_ram
  import burst_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bit_mask_c;

  always_comb begin
    bit_mask_c = '0;
    for (int b = 0; b < BE_W; b++) begin
      bit_mask_c[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= (mem[addr] & ~bit_mask_c) | (wr_data & bit_mask_c);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/burst_ram_slave.sv
// Bus slave serving DMA burst reads/writes from an on-chip RAM with
// programmable read latency and periodic write back-pressure.
module burst_ram_slave
  import burst_slave_pkg::*;
#(
  parameter logic [31:0] baseAddress   = 32'h5000_0000,
  parameter int unsigned nrOfWordsLog2 = 10,
  parameter int unsigned readLatency   = 2,
  parameter int unsigned busyEvery     = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                begin_transaction_in,
  input  logic [DATA_W-1:0]   address_data_in,
  input  logic [BE_W-1:0]     byte_enables_in,
  input  logic [BURST_W-1:0]  burst_size_in,
  input  logic                read_n_write_in,
  input  logic                data_valid_in,
  input  logic                end_transaction_in,
  output logic [DATA_W-1:0]   address_data_out,
  output logic                data_valid_out,
  output logic                end_transaction_out,
  output logic                busy_out,
  output logic                error_out
);

  localparam int unsigned AW     = nrOfWordsLog2;
  localparam int unsigned LAT_W  = 8;
  localparam int unsigned BEAT_W = 8;

  logic [2:0]         state, state_nxt;
  logic [AW-1:0]      idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BURST_W-1:0] burst, burst_nxt;
  logic [LAT_W-1:0]   lat, lat_nxt;
  logic [BEAT_W-1:0]  beat, beat_nxt;
  logic               ovf, ovf_nxt;
  logic               dv_nxt, end_nxt, busy_nxt, err_nxt;
  logic               rd_c, wr_c;
  logic [AW-1:0]      ram_addr_c;
  logic [DATA_W-1:0]  offset_c;
  logic [AW-1:0]      word_idx_c;
  logic               sel_c;
  logic               unused_c;
  wr_beat_t           wr_beat_c;

  // Window decode; byte offset bits [1:0] are don't-care.
  assign offset_c   = address_data_in - baseAddress;
  assign word_idx_c = offset_c[AW+1:2];
  assign sel_c      = begin_transaction_in && (address_data_in >= baseAddress)
                      && (offset_c[DATA_W-1:AW+2] == '0);
  assign unused_c   = ^offset_c[1:0];
  assign wr_beat_c  = '{data: address_data_in, be: byte_enables_in};
  assign ram_addr_c = idx + AW'(cnt);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    burst_nxt = burst;
    lat_nxt   = lat;
    beat_nxt  = beat;
    ovf_nxt   = ovf;
    dv_nxt    = 1'b0;
    end_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    err_nxt   = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sel_c) begin
          idx_nxt   = word_idx_c;
          burst_nxt = burst_size_in;
          cnt_nxt   = '0;
          lat_nxt   = '0;
          beat_nxt  = '0;
          ovf_nxt   = 1'b0;
          if (!inRange(DATA_W'(word_idx_c), burst_size_in, AW)) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else if (read_n_write_in) begin
            state_nxt = ST_READ_WAIT;
          end else begin
            state_nxt = ST_WRITE;
          end
        end
      end

      // The RAM read is issued in the last wait cycle so data lands one cycle later.
      ST_READ_WAIT: begin
        if (end_transaction_in) begin
          state_nxt = ST_IDLE;
        end else if (lat == LAT_W'(readLatency - 1)) begin
          rd_c      = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = ST_READ_BURST;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end

      ST_READ_BURST: begin
        if (end_transaction_in) begin
          state_nxt = ST_IDLE;
        end else if (cnt <= {1'b0, burst}) begin
          rd_c    = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          state_nxt = ST_READ_END;
          end_nxt   = 1'b1;
        end
      end

      ST_READ_END: state_nxt = ST_IDLE;

      ST_WRITE: begin
        if (data_valid_in && !busy_out) begin
          if (cnt <= {1'b0, burst}) begin
            wr_c    = 1'b1;
            cnt_nxt = cnt + CNT_W'(1);
            if (busyEvery != 0) begin
              if (beat == BEAT_W'(busyEvery - 1)) begin
                busy_nxt = 1'b1;
                beat_nxt = '0;
              end else begin
                beat_nxt = beat + BEAT_W'(1);
              end
            end
          end else if (!ovf) begin
            ovf_nxt = 1'b1;
            err_nxt = 1'b1;
          end
        end
        if (end_transaction_in) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_ERROR: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase

    dv_nxt = rd_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ST_IDLE;
      idx                 <= '0;
      cnt                 <= '0;
      burst               <= '0;
      lat                 <= '0;
      beat                <= '0;
      ovf                 <= 1'b0;
      data_valid_out      <= 1'b0;
      end_transaction_out <= 1'b0;
      busy_out            <= 1'b0;
      error_out           <= 1'b0;
    end else begin
      state               <= state_nxt;
      idx                 <= idx_nxt;
      cnt                 <= cnt_nxt;
      burst               <= burst_nxt;
      lat                 <= lat_nxt;
      beat                <= beat_nxt;
      ovf                 <= ovf_nxt;
      data_valid_out      <= dv_nxt;
      end_transaction_out <= end_nxt;
      busy_out            <= busy_nxt;
      error_out           <= err_nxt;
    end
  end

  // RAM output register doubles as the read-data output register.
  burst_slave_ram #(
    .ADDR_W (AW)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (rd_c),
    .wr_en   (wr_c && !reset),
    .addr    (ram_addr_c),
    .wr_data (wr_beat_c.data),
    .wr_be   (wr_beat_c.be),
    .rd_data (address_data_out)
  );

endmodule
